// File: rtl/wrapper_input_conditioner.sv
// Purpose : pixel clock-enable / divided clock plus N-key synchroniser, debouncer
//           and press / release / auto-repeat event generator for a game wrapper.
// Latency : raw key pin to key_lvl is 2 + DB_CYCLES clk; events are registered.
// Backpress: none; press/release events are held until the end of the next pix_en
//           cycle so the pixel-rate domain cannot miss them.
// Ports   : clk, reset (async, active low), keys[KEY_N] raw pins ->
//           pix_en, pix_clk, key_lvl, key_press, key_rel, key_rpt (all KEY_N wide
//           except pix_en / pix_clk).
module wrapper_input_conditioner #(
  parameter int KEY_N          = 4,
  parameter int DIV            = 2,
  parameter int DB_CYCLES      = 16,
  parameter bit KEY_ACTIVE_LOW = 1'b0,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_PERIOD  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_N-1:0] keys,
  output logic             pix_en,
  output logic             pix_clk,
  output logic [KEY_N-1:0] key_lvl,
  output logic [KEY_N-1:0] key_press,
  output logic [KEY_N-1:0] key_rel,
  output logic [KEY_N-1:0] key_rpt
);

  localparam int PW      = $clog2(DIV + 1);
  localparam int DW      = $clog2(DB_CYCLES + 1);
  localparam int RMAX_R  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RMAX    = (RMAX_R < 1) ? 1 : RMAX_R;
  localparam int RW      = $clog2(RMAX + 1);

  localparam logic [PW-1:0]    PH_LAST   = PW'(DIV - 1);
  // Real-valued DIV/2 threshold: phase*2 >= DIV, i.e. phase >= ceil(DIV/2).
  localparam logic [PW-1:0]    PH_HIGH   = PW'((DIV + 1) / 2);
  localparam logic [DW-1:0]    DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]    RP_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0]    RP_PERIOD = RW'(REPEAT_PERIOD);
  localparam logic [KEY_N-1:0] KEY_IDLE  = {KEY_N{KEY_ACTIVE_LOW}};

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_PERIOD} rpt_state_t;

  logic [PW-1:0]    phase_q, phase_d;
  logic             pix_en_q, pix_en_d, pix_clk_q, pix_clk_d;
  logic [KEY_N-1:0] sync1_q, sync1_d, sync2_q, sync2_d, key_s;
  logic [KEY_N-1:0] lvl_q, lvl_d, rise_ev, fall_ev;
  logic [DW-1:0]    db_cnt_q [KEY_N];
  logic [DW-1:0]    db_cnt_d [KEY_N];
  logic [KEY_N-1:0] press_q, press_d, rel_q, rel_d, rpt_q, rpt_d;
  rpt_state_t       rpt_st_q [KEY_N];
  rpt_state_t       rpt_st_d [KEY_N];
  logic [RW-1:0]    rpt_cnt_q [KEY_N];
  logic [RW-1:0]    rpt_cnt_d [KEY_N];
  logic [RW-1:0]    rpt_inc [KEY_N];

  // Divider: pix_en / pix_clk are registered from the current phase, so the
  // first pix_en lands in cycle DIV after reset release.
  always_comb begin
    phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    pix_en_d  = (phase_q == PH_LAST);
    pix_clk_d = (DIV > 1) && (phase_q >= PH_HIGH);
  end

  // Two-flop synchroniser; polarity fixed after the second flop.
  always_comb begin
    sync1_d = keys;
    sync2_d = sync1_q;
    key_s   = sync2_q ^ KEY_IDLE;
  end

  // Debounce: any return to the accepted level restarts the count.
  always_comb begin
    lvl_d   = lvl_q;
    rise_ev = '0;
    fall_ev = '0;
    for (int k = 0; k < KEY_N; k++) begin
      db_cnt_d[k] = '0;
      if (key_s[k] != lvl_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          lvl_d[k]   = key_s[k];
          rise_ev[k] = key_s[k];
          fall_ev[k] = ~key_s[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DW'(1);
        end
      end
    end
  end

  // Event hold: a new event on the clearing edge takes priority.
  always_comb begin
    press_d = rise_ev | (press_q & ~{KEY_N{pix_en_q}});
    rel_d   = fall_ev | (rel_q & ~{KEY_N{pix_en_q}});
  end

  // Auto-repeat next-state: counts pix_en ticks while the key is held.
  always_comb begin
    rpt_d = rpt_q;
    for (int k = 0; k < KEY_N; k++) begin
      rpt_st_d[k]  = rpt_st_q[k];
      rpt_cnt_d[k] = rpt_cnt_q[k];
      rpt_inc[k]   = rpt_cnt_q[k] + RW'(1);
      if (REPEAT_DELAY == 0) begin
        rpt_st_d[k]  = RPT_IDLE;
        rpt_cnt_d[k] = '0;
        rpt_d[k]     = 1'b0;
      end else if (fall_ev[k]) begin
        rpt_st_d[k]  = RPT_IDLE;
        rpt_cnt_d[k] = '0;
        rpt_d[k]     = 1'b0;
      end else if (rise_ev[k]) begin
        rpt_st_d[k]  = RPT_DELAY;
        rpt_cnt_d[k] = '0;
        rpt_d[k]     = 1'b0;
      end else if (pix_en_q && lvl_q[k]) begin
        // A repeat lasts exactly one pix_en period.
        rpt_d[k] = 1'b0;
        case (rpt_st_q[k])
          RPT_DELAY: begin
            if (rpt_inc[k] == RP_DELAY) begin
              rpt_d[k]     = 1'b1;
              rpt_cnt_d[k] = '0;
              rpt_st_d[k]  = RPT_PERIOD;
            end else begin
              rpt_cnt_d[k] = rpt_inc[k];
            end
          end
          RPT_PERIOD: begin
            if (REPEAT_PERIOD == 0) begin
              rpt_st_d[k] = RPT_IDLE;
            end else if (rpt_inc[k] == RP_PERIOD) begin
              rpt_d[k]     = 1'b1;
              rpt_cnt_d[k] = '0;
            end else begin
              rpt_cnt_d[k] = rpt_inc[k];
            end
          end
          default: begin
            rpt_cnt_d[k] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= '0;
      pix_en_q  <= 1'b0;
      pix_clk_q <= 1'b0;
      sync1_q   <= KEY_IDLE;
      sync2_q   <= KEY_IDLE;
      lvl_q     <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      rpt_q     <= '0;
      for (int k = 0; k < KEY_N; k++) begin
        db_cnt_q[k]  <= '0;
        rpt_cnt_q[k] <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      pix_en_q  <= pix_en_d;
      pix_clk_q <= pix_clk_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      rpt_q     <= rpt_d;
      for (int k = 0; k < KEY_N; k++) begin
        db_cnt_q[k]  <= db_cnt_d[k];
        rpt_cnt_q[k] <= rpt_cnt_d[k];
      end
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < KEY_N; k++) rpt_st_q[k] <= RPT_IDLE;
    end else begin
      for (int k = 0; k < KEY_N; k++) rpt_st_q[k] <= rpt_st_d[k];
    end
  end

  assign pix_en    = pix_en_q;
  assign pix_clk   = pix_clk_q;
  assign key_lvl   = lvl_q;
  assign key_press = press_q;
  assign key_rel   = rel_q;
  assign key_rpt   = rpt_q;

endmodule
